// File: rtl/keccak_msg_packer.sv
// keccak_msg_packer: packs a byte-length-tagged stream of DW-bit words into
// IW-bit words for the Keccak-512 core. The first byte goes in the MSBs. It
// also generates the core framing (is_last / byte_num), including an extra
// empty final word when the length is a multiple of IW/8.
// Optional build macro: KECCAK_PACK_BYTESWAP_EN. When it is defined, each din
// beat is byte-reversed before packing, so the upstream is treated as
// little-endian.
module keccak_msg_packer #(
    parameter int IW   = 128,
    parameter int DW   = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [LENW-1:0] msg_len,
    output logic            idle,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [IW-1:0]   k_in,
    output logic            k_in_ready,
    output logic            k_is_last,
    output logic [3:0]      k_byte_num,
    input  logic            k_buffer_full,
    output logic            done
);

    localparam int BPW = IW / 8;             // bytes per core word
    localparam int BPD = DW / 8;             // bytes per din beat
    localparam int NB  = IW / DW;            // din beats per core word
    localparam int CW  = $clog2(NB + 1);     // beat counter width
    localparam int LBW = $clog2(BPD + 1);    // valid-bytes-in-last-beat width

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SEND,
        S_LAST,
        S_DONE
    } state_t;

    state_t          r_state, r_state_next;
    logic [LENW-1:0] r_words_left, r_words_left_next;   // din beats still to take
    logic [LENW-1:0] r_full_left, r_full_left_next;     // full core words still to send
    logic [3:0]      r_rem, r_rem_next;                 // bytes in the final word
    logic [LBW-1:0]  r_last_bytes, r_last_bytes_next;   // valid bytes in final din beat
    logic [CW-1:0]   r_beats, r_beats_next;             // beats held for current word
    logic [IW-1:0]   r_pack, r_pack_next;               // packing register

    logic [LENW:0]   w_len_ext;
    logic [LENW-1:0] w_words;
    logic [LENW-1:0] w_full;
    logic [3:0]      w_rem;
    logic [LBW-1:0]  w_lb_mod;
    logic [LBW-1:0]  w_last_bytes;
    logic [DW-1:0]   w_din_ord;
    logic [DW-1:0]   w_beat;
    logic [IW-1:0]   w_shifted;
    logic            w_final_beat;

    // Framing derived from the requested length, captured together with start.
    assign w_len_ext    = {1'b0, msg_len};
    assign w_words      = LENW'((w_len_ext + (LENW+1)'(BPD - 1)) / (LENW+1)'(BPD));
    assign w_full       = msg_len / LENW'(BPW);
    assign w_rem        = 4'(msg_len % LENW'(BPW));
    assign w_lb_mod     = LBW'(msg_len % LENW'(BPD));
    assign w_last_bytes = (w_lb_mod == '0) ? LBW'(BPD) : w_lb_mod;

    assign w_final_beat = (r_words_left == LENW'(1));

    // Byte order of the upstream beat.
`ifdef KECCAK_PACK_BYTESWAP_EN
    generate
        for (genvar gi = 0; gi < BPD; gi++) begin : g_swap
            assign w_din_ord[DW-1-8*gi -: 8] = din[8*gi +: 8];
        end
    endgenerate
`else
    assign w_din_ord = din;
`endif

    // Zero the bytes past the message end on the final beat. This happens after any swap.
    generate
        for (genvar gi = 0; gi < BPD; gi++) begin : g_mask
            assign w_beat[DW-1-8*gi -: 8] =
                (w_final_beat && (LBW'(gi) >= r_last_bytes)) ? 8'h00 : w_din_ord[DW-1-8*gi -: 8];
        end
    endgenerate

    // Shift the new beat in at the LSB end. After NB beats, the first beat sits in the MSBs.
    generate
        if (NB > 1) begin : g_shift
            assign w_shifted = {r_pack[IW-DW-1:0], w_beat};
        end else begin : g_noshift
            assign w_shifted = w_beat;
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_words_left <= '0;
            r_full_left  <= '0;
            r_rem        <= '0;
            r_last_bytes <= '0;
            r_beats      <= '0;
            r_pack       <= '0;
        end else begin
            r_state      <= r_state_next;
            r_words_left <= r_words_left_next;
            r_full_left  <= r_full_left_next;
            r_rem        <= r_rem_next;
            r_last_bytes <= r_last_bytes_next;
            r_beats      <= r_beats_next;
            r_pack       <= r_pack_next;
        end
    end

    // Next-state, datapath updates and outputs decoded from registered state.
    always_comb begin
        r_state_next      = r_state;
        r_words_left_next = r_words_left;
        r_full_left_next  = r_full_left;
        r_rem_next        = r_rem;
        r_last_bytes_next = r_last_bytes;
        r_beats_next      = r_beats;
        r_pack_next       = r_pack;

        idle       = (r_state == S_IDLE);
        din_ready  = (r_state == S_FILL) && (r_words_left != '0) && (r_beats < CW'(NB));
        k_in_ready = (r_state == S_SEND) || (r_state == S_LAST);
        k_is_last  = (r_state == S_LAST);
        k_byte_num = (r_state == S_LAST) ? r_rem : 4'd0;
        k_in       = k_in_ready ? r_pack : '0;
        done       = (r_state == S_DONE);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_words_left_next = w_words;
                    r_full_left_next  = w_full;
                    r_rem_next        = w_rem;
                    r_last_bytes_next = w_last_bytes;
                    r_beats_next      = '0;
                    r_pack_next       = '0;
                    if (w_full == '0 && w_words == '0)
                        r_state_next = S_LAST;
                    else
                        r_state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (din_valid && din_ready) begin
                    r_words_left_next = r_words_left - LENW'(1);
                    if (r_full_left != '0) begin
                        // Filling a full word.
                        r_pack_next = w_shifted;
                        if (r_beats == CW'(NB - 1)) begin
                            r_beats_next = '0;
                            r_state_next = S_SEND;
                        end else begin
                            r_beats_next = r_beats + CW'(1);
                        end
                    end else if (w_final_beat) begin
                        // The partial final word is complete. Left-align it.
                        r_pack_next  = w_shifted << ((NB - 1 - int'(r_beats)) * DW);
                        r_beats_next = '0;
                        r_state_next = S_LAST;
                    end else begin
                        r_pack_next  = w_shifted;
                        r_beats_next = r_beats + CW'(1);
                    end
                end
            end
            S_SEND: begin
                if (!k_buffer_full) begin
                    r_full_left_next = r_full_left - LENW'(1);
                    if (r_full_left == LENW'(1) && r_rem == 4'd0) begin
                        r_pack_next  = '0;
                        r_state_next = S_LAST;
                    end else begin
                        r_state_next = S_FILL;
                    end
                end
            end
            S_LAST: begin
                if (!k_buffer_full)
                    r_state_next = S_DONE;
            end
            S_DONE: begin
                r_state_next = S_IDLE;
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_msg_packer.sv
// Scoreboard bench for keccak_msg_packer (default big-endian build).
// The stimulus pushes the hand-computed core words. A negedge monitor pops
// and compares them on every core transfer, and it also checks the done pulse.
module tb_keccak_msg_packer;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [15:0]  msg_len;
    logic         idle;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] k_in;
    logic         k_in_ready;
    logic         k_is_last;
    logic [3:0]   k_byte_num;
    logic         k_buffer_full;
    logic         done;

    keccak_msg_packer #(.IW(128), .DW(32), .LENW(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .msg_len       (msg_len),
        .idle          (idle),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         l;
        logic [3:0]   bn;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] din_q[$];
    int          n_cmp;
    int          n_err;
    bit          pending_done;
    logic [127:0] bp_exp;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic l, input logic [3:0] bn);
        exp_t e;
        e.d  = d;
        e.l  = l;
        e.bn = bn;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_idle"},       128'(idle),       128'(1));
        chk({tag, "_din_ready"},  128'(din_ready),  128'(0));
        chk({tag, "_k_in"},       k_in,             128'(0));
        chk({tag, "_k_in_ready"}, 128'(k_in_ready), 128'(0));
        chk({tag, "_k_is_last"},  128'(k_is_last),  128'(0));
        chk({tag, "_k_byte_num"}, 128'(k_byte_num), 128'(0));
        chk({tag, "_done"},       128'(done),       128'(0));
    endtask

    // Monitor: compare every core transfer against the scoreboard, and check the done pulse.
    initial begin
        exp_t e;
        pending_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pending_done = 1'b0;
            end else begin
                if (pending_done) begin
                    chk("done_pulse", 128'(done), 128'(1));
                    pending_done = 1'b0;
                end else if (done) begin
                    chk("spurious_done", 128'(done), 128'(0));
                end
                if (k_in_ready && !k_buffer_full) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_word: got %0h expected no word", k_in);
                    end else begin
                        e = sb_q.pop_front();
                        $display("word: k_in=%032h last=%0b byte_num=%0d (exp %032h %0b %0d)",
                                 k_in, k_is_last, k_byte_num, e.d, e.l, e.bn);
                        chk("k_in",       k_in,             e.d);
                        chk("k_is_last",  128'(k_is_last),  128'(e.l));
                        chk("k_byte_num", 128'(k_byte_num), 128'(e.bn));
                        if (e.l) pending_done = 1'b1;
                    end
                end
            end
        end
    end

    // Run one message. din_valid stays high throughout, and extra garbage beats are offered
    // to show that they are left unconsumed.
    task automatic run_msg(input int len, input int exp_beats, input bit rnd, input bit bp);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        int post = 0;
        bit bp_rel = 1'b0;
        bit seen_done = 1'b0;
        bit xfer;
        @(posedge clk); #1;
        start   = 1'b1;
        msg_len = 16'(len);
        @(posedge clk); #1;
        start     = 1'b0;
        din_valid = 1'b1;
        while (!seen_done && cyc < 3000) begin
            din = (idx < din_q.size()) ? din_q[idx] : 32'hFFFF_FFFF;
            if (bp)       k_buffer_full = !bp_rel;
            else if (rnd) k_buffer_full = ($urandom_range(0, 2) == 0);
            else          k_buffer_full = 1'b0;
            @(negedge clk);
            xfer = din_valid && din_ready;
            if (bp && bp_rel) begin
                post++;
                if (post == 1) chk("bp_still_send", 128'({k_in_ready, k_is_last}), 128'(2'b10));
                if (post == 2) chk("bp_xfer_first", 128'(k_is_last), 128'(1));
            end
            if (bp && !bp_rel && k_in_ready && k_buffer_full) begin
                stall++;
                chk("bp_k_in",      k_in,            bp_exp);
                chk("bp_din_ready", 128'(din_ready), 128'(0));
                chk("bp_is_last",   128'(k_is_last), 128'(0));
                if (stall == 3) bp_rel = 1'b1;
            end
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        din_valid     = 1'b0;
        k_buffer_full = 1'b0;
        if (!seen_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
        end
        $display("msg len=%0d: beats taken=%0d (exp %0d) cycles=%0d", len, idx, exp_beats, cyc);
        chk("beats_taken", 128'(idx), 128'(exp_beats));
        chk("sb_drained",  128'(sb_q.size()), 128'(0));
        @(negedge clk);
        chk("idle_after", 128'(idle), 128'(1));
    endtask

    initial begin
        int idx;
        int cyc;
        bit xfer;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        start = 1'b0;
        msg_len = '0;
        din = '0;
        din_valid = 1'b0;
        k_buffer_full = 1'b0;
        bp_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Empty message.
        din_q.delete();
        push(128'h0, 1'b1, 4'd0);
        run_msg(0, 0, 1'b0, 1'b0);

        // Short message, 5 bytes.
        din_q = '{32'hA1A2A3A4, 32'hA5FFFFFF};
        push(128'hA1A2A3A4_A5000000_00000000_00000000, 1'b1, 4'd5);
        run_msg(5, 2, 1'b0, 1'b0);

        // Aligned message, 16 bytes.
        din_q = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        push(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b0, 4'd0);
        push(128'h0, 1'b1, 4'd0);
        run_msg(16, 4, 1'b0, 1'b0);

        // Back-pressure on the full word.
        bp_exp = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        push(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b0, 4'd0);
        push(128'h0, 1'b1, 4'd0);
        run_msg(16, 4, 1'b0, 1'b1);

        // Multi-block, 196 bytes, random back-pressure.
        din_q.delete();
        for (int i = 0; i < 49; i++) din_q.push_back(32'h61626364);
        for (int i = 0; i < 12; i++) push({4{32'h61626364}}, 1'b0, 4'd0);
        push(128'h61626364_00000000_00000000_00000000, 1'b1, 4'd4);
        run_msg(196, 49, 1'b1, 1'b0);

        // Reset in the middle of a 16-byte message after two beats.
        @(posedge clk); #1;
        start   = 1'b1;
        msg_len = 16'd16;
        @(posedge clk); #1;
        start     = 1'b0;
        din_valid = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 2 && cyc < 50) begin
            din = (idx == 0) ? 32'h11111111 : 32'h22222222;
            @(negedge clk);
            xfer = din_valid && din_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        chk("abort_beats", 128'(idx), 128'(2));
        din_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Short message again after the abort.
        din_q = '{32'hA1A2A3A4, 32'hA5FFFFFF};
        push(128'hA1A2A3A4_A5000000_00000000_00000000, 1'b1, 4'd5);
        run_msg(5, 2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
